// File: rtl/ga_pkg.sv
// Shared types and constants for the GA parent-selection datapath.
package ga_pkg;

  typedef logic signed [7:0] indiv_t;

  // Default-width fitness; the selector itself is parameterised on FIT_W.
  typedef logic [15:0] fitness_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    StIdle,
    StPick1,
    StPick2,
    StEmit,
    StDone
  } sel_state_e;

endpackage

// File: rtl/ga_lfsr16.sv
// 16-bit left-shifting Fibonacci LFSR; steps only when adv is high.
module ga_lfsr16
  import ga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_d;

  always_comb begin
    q_d = q;
    if (adv) begin
      q_d = {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= seed;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/ga_tournament_select.sv
// Tournament parent selector: buffers a population and emits LFSR-driven parent pairs.
// Optional feature macro: GA_ELITE_EN adds elite / elite_fitness tracking of loaded individuals.
module ga_tournament_select
  import ga_pkg::*;
#(
  parameter int unsigned POP_SIZE  = 16,
  parameter int unsigned FIT_W     = 16,
  parameter int unsigned N_PAIRS   = POP_SIZE / 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  input  logic signed [7:0]       load_data,
  input  logic [FIT_W-1:0]        load_fitness,
  input  logic                    start,
  output logic                    pop_full,
  output logic                    busy,
  output logic signed [7:0]       parent1,
  output logic signed [7:0]       parent2,
  output logic                    pair_valid,
  output logic                    done
`ifdef GA_ELITE_EN
  ,
  output logic signed [7:0]       elite,
  output logic [FIT_W-1:0]        elite_fitness
`endif
);

  localparam int unsigned IDX_W = $clog2(POP_SIZE);
  localparam int unsigned CNT_W = $clog2(POP_SIZE + 1);
  localparam int unsigned PC_W  = $clog2(N_PAIRS + 1);
  localparam logic [CNT_W-1:0] POP_CNT   = CNT_W'(POP_SIZE);
  localparam logic [PC_W-1:0]  LAST_PAIR = PC_W'(N_PAIRS - 1);

  if (2 * IDX_W > 16) begin : g_bad_idx_w
    $error("POP_SIZE too large: two tournament indices must fit in the 16-bit LFSR");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  sel_state_e       state_q;
  logic [IDX_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [PC_W-1:0]  pair_cnt_q;
  indiv_t           p1_q, p2_q, parent1_q, parent2_q;
  logic             pair_valid_q, done_q;

  indiv_t           mem_q [POP_SIZE];
  logic [FIT_W-1:0] fit_q [POP_SIZE];

  logic [15:0]      lfsr_q;
  logic             lfsr_adv;
  logic [IDX_W-1:0] idx_a, idx_b;
  indiv_t           winner;
  logic             load_acc;
  logic             unused_lfsr;

  assign load_acc = load_valid && (state_q == StIdle);
  assign lfsr_adv = (state_q == StPick1) || (state_q == StPick2);

  ga_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (lfsr_adv),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // Bits above the two index fields are only used for sequence length.
  assign unused_lfsr = ^lfsr_q;

  assign idx_a  = lfsr_q[IDX_W-1:0];
  assign idx_b  = lfsr_q[2*IDX_W-1:IDX_W];
  // Strict compare: ties (and idx_a == idx_b) keep idx_a.
  assign winner = (fit_q[idx_b] > fit_q[idx_a]) ? mem_q[idx_b] : mem_q[idx_a];

  // Population storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      mem_q[wr_ptr_q] <= load_data;
      fit_q[wr_ptr_q] <= load_fitness;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pair_cnt_q   <= '0;
      p1_q         <= '0;
      p2_q         <= '0;
      parent1_q    <= '0;
      parent2_q    <= '0;
      pair_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      pair_valid_q <= 1'b0;
      done_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_valid) begin
            wr_ptr_q <= wr_ptr_q + IDX_W'(1);
            if (count_q != POP_CNT) begin
              count_q <= count_q + CNT_W'(1);
            end
          end
          if (start && pop_full) begin
            state_q <= StPick1;
          end
        end
        StPick1: begin
          p1_q    <= winner;
          state_q <= StPick2;
        end
        StPick2: begin
          p2_q    <= winner;
          state_q <= StEmit;
        end
        StEmit: begin
          parent1_q    <= p1_q;
          parent2_q    <= p2_q;
          pair_valid_q <= 1'b1;
          pair_cnt_q   <= pair_cnt_q + PC_W'(1);
          state_q      <= (pair_cnt_q == LAST_PAIR) ? StDone : StPick1;
        end
        StDone: begin
          done_q     <= 1'b1;
          pair_cnt_q <= '0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pop_full   = (count_q == POP_CNT);
  assign busy       = (state_q == StPick1) || (state_q == StPick2) || (state_q == StEmit);
  assign parent1    = parent1_q;
  assign parent2    = parent2_q;
  assign pair_valid = pair_valid_q;
  assign done       = done_q;

`ifdef GA_ELITE_EN
  indiv_t           elite_q;
  logic [FIT_W-1:0] elite_fit_q;
  logic             elite_seen_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      elite_q      <= '0;
      elite_fit_q  <= '0;
      elite_seen_q <= 1'b0;
    end else if (load_acc && (!elite_seen_q || (load_fitness > elite_fit_q))) begin
      elite_q      <= load_data;
      elite_fit_q  <= load_fitness;
      elite_seen_q <= 1'b1;
    end
  end

  assign elite         = elite_q;
  assign elite_fitness = elite_fit_q;
`endif

endmodule

// File: tb/tb_ga_tournament_select.sv
// Scoreboard bench for ga_tournament_select; expected pairs are queued at start, checked by a monitor.
module tb_ga_tournament_select;
  import ga_pkg::*;

  localparam int NP = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_valid;
  logic signed [7:0] load_data;
  logic [15:0]       load_fitness;
  logic              start;
  logic              pop_full, busy, pair_valid, done;
  logic signed [7:0] parent1, parent2;
`ifdef GA_ELITE_EN
  logic signed [7:0] elite;
  logic [15:0]       elite_fitness;
`endif

  always #5 clk = ~clk;

  ga_tournament_select dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_fitness (load_fitness),
    .start        (start),
    .pop_full     (pop_full),
    .busy         (busy),
    .parent1      (parent1),
    .parent2      (parent2),
    .pair_valid   (pair_valid),
    .done         (done)
`ifdef GA_ELITE_EN
    ,
    .elite        (elite),
    .elite_fitness(elite_fitness)
`endif
  );

  typedef struct {
    logic signed [7:0] p1;
    logic signed [7:0] p2;
    int                cyc;
  } pair_t;

  pair_t    pair_q[$];
  int       done_q[$];
  int       checks = 0;
  int       failures = 0;
  int       cyc = 0;
  int       pairs_seen = 0;
  int       dones_seen = 0;
  indiv_t   m_data[16];
  fitness_t m_fit[16];
  logic [15:0] m_lfsr;
  int       m_wr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic indiv_t tourney(input logic [15:0] l);
    logic [3:0] a, b;
    a = l[3:0];
    b = l[7:4];
    return (m_fit[b] > m_fit[a]) ? m_data[b] : m_data[a];
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a pair or done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pair_valid) begin
        pairs_seen++;
        if (pair_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pair: got %0d/%0d expected none", parent1, parent2);
        end else begin
          pair_t e;
          e = pair_q.pop_front();
          chk("parent1", parent1, e.p1);
          chk("parent2", parent2, e.p2);
          chk("pair_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        dones_seen++;
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got pulse at %0d expected none", cyc);
        end else begin
          chk("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  task automatic load_one(input logic signed [7:0] d, input logic [15:0] f);
    load_valid   = 1'b1;
    load_data    = d;
    load_fitness = f;
    m_data[m_wr] = d;
    m_fit[m_wr]  = f;
    m_wr         = (m_wr + 1) % 16;
    @(posedge clk); #1;
    load_valid   = 1'b0;
  endtask

  // Issue start and queue the whole run; optionally pin the first pair to hand values.
  task automatic do_start(input bit use_hand, input logic signed [7:0] h1,
                          input logic signed [7:0] h2);
    int s;
    pair_t e;
    start = 1'b1;
    s = cyc;
    for (int k = 0; k < NP; k++) begin
      e.p1 = tourney(m_lfsr);
      m_lfsr = lfsr_next(m_lfsr);
      e.p2 = tourney(m_lfsr);
      m_lfsr = lfsr_next(m_lfsr);
      e.cyc = s + 4 + 3 * k;
      if (use_hand && k == 0) begin
        e.p1 = h1;
        e.p2 = h2;
      end
      pair_q.push_back(e);
    end
    done_q.push_back(s + 4 + 3 * (NP - 1) + 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int  n;
    bit  seen;
    n = dones_seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (dones_seen > n) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected within %0d cycles", max_cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    m_lfsr = 16'hACE1;
    m_wr   = 0;
    pair_q.delete();
    done_q.delete();
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) load_one(8'(i - 8), 16'(i));
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    load_fitness = '0;
    start = 1'b0;
    m_lfsr = 16'hACE1;
    m_wr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_parent1", parent1, 0);
    chk("rst_parent2", parent2, 0);
    chk("rst_pair_valid", pair_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pop_full", pop_full, 0);

    // Start with only 15 individuals is ignored.
    for (int i = 0; i < 15; i++) load_one(8'(i - 8), 16'(i));
    chk("pop_full_15", pop_full, 0);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("busy_not_full", busy, 0);
    end
    start = 1'b0;
    load_one(8'(7), 16'(15));
    chk("pop_full_16", pop_full, 1);

    // Ramp population: seed 0xACE1 gives idx (1,14) then (3,12) -> data 6, 4.
    do_start(1'b1, 8'sd6, 8'sd4);
    #1;
    chk("busy_running", busy, 1);
    wait_done(60);
    chk("busy_after_run", busy, 0);

    // All-equal fitness: every parent must be data[idx_a].
    for (int i = 0; i < 16; i++) load_one(8'(i * 5 - 40), 16'd100);
    do_start(1'b0, 8'sd0, 8'sd0);
    wait_done(60);

    // Mid-run start/load attempts must not disturb the run or the memory.
    for (int i = 0; i < 16; i++) load_one(8'(i * 7 - 50), 16'((i * 37) % 23));
    do_start(1'b0, 8'sd0, 8'sd0);
    repeat (4) @(posedge clk);
    #1;
    start        = 1'b1;
    load_valid   = 1'b1;
    load_data    = -8'sd1;
    load_fitness = 16'hFFFF;
    repeat (6) @(posedge clk);
    #1;
    start      = 1'b0;
    load_valid = 1'b0;
    chk("pop_full_mid", pop_full, 1);
    wait_done(60);
    do_start(1'b0, 8'sd0, 8'sd0);
    wait_done(60);

    // Reset after the third pair aborts the run and restarts the LFSR.
    load_ramp();
    begin
      int base;
      bit hit;
      base = pairs_seen;
      do_start(1'b0, 8'sd0, 8'sd0);
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
        @(negedge clk);
        if (pairs_seen >= base + 3) hit = 1'b1;
      end
      if (!hit) begin
        checks++;
        failures++;
        $display("FAIL third_pair_timeout: got %0d pairs expected 3", pairs_seen - base);
      end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_parent1", parent1, 0);
    chk("abort_parent2", parent2, 0);
    chk("abort_pair_valid", pair_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pop_full", pop_full, 0);
    rst_n  = 1'b1;
    m_lfsr = 16'hACE1;
    m_wr   = 0;
    pair_q.delete();
    done_q.delete();
    load_ramp();
    do_start(1'b1, 8'sd6, 8'sd4);
    wait_done(60);

    chk("pairs_left", pair_q.size(), 0);
    chk("dones_left", done_q.size(), 0);

`ifdef GA_ELITE_EN
    do_reset();
    chk("elite_rst", elite, 0);
    chk("elite_fit_rst", elite_fitness, 0);
    load_one(8'sd10, 16'd5);
    load_one(8'sd20, 16'd9);
    load_one(8'sd30, 16'd9);
    load_one(8'sd40, 16'd3);
    chk("elite", elite, 20);
    chk("elite_fitness", elite_fitness, 9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
